ttt_move_ctrl: RTL and testbench
================================

TTT_MOVE_CTRL -- requirements
Module: ttt_move_ctrl

Interface
REQ-001 SHALL have parameter FIRST_PLAYER, default 0, symbol of the player moving first after reset or new game (0 = X, 1 = O).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port new_game  input  1  single-cycle request to clear the board and restart.
REQ-005 SHALL have port move_vld  input  1  move request valid.
REQ-006 SHALL have port move_idx  input  4  target cell index, 0..8, row-major.
REQ-007 SHALL have port move_rdy  output  1  controller able to accept a move.
REQ-008 SHALL have port cell_valid  input  9  occupied flags from the nine cells.
REQ-009 SHALL have port cell_symbol  input  9  stored symbols from the nine cells.
REQ-010 SHALL have port cell_set  output  9  one-hot set strobe to the cells.
REQ-011 SHALL have port set_symbol  output  1  symbol written with cell_set; equals turn.
REQ-012 SHALL have port cell_reset  output  1  clear strobe to all cells.
REQ-013 SHALL have port turn  output  1  symbol of the player to move.
REQ-014 SHALL have port game_over  output  1  game finished.
REQ-015 SHALL have port winner  output  2  00 none, 01 X, 10 O, 11 draw.
REQ-016 SHALL have port illegal  output  1  one-cycle pulse on a rejected move.

Function
REQ-017 SHALL implement FSM states IDLE, SET, WAIT, CHECK, OVER, CLEAR.
REQ-018 Handshake: move accepted in IDLE when move_vld && move_rdy; move_rdy = (state == IDLE).
REQ-019 Rejected move (move_idx > 8, or cell_valid[move_idx] = 1): pulse illegal for one cycle in the cycle after acceptance; state stays IDLE; turn unchanged.
REQ-020 Legal move: latch move_idx, go IDLE -> SET; in SET, cell_set[idx] = 1 for exactly one cycle, all other bits 0, set_symbol = turn.
REQ-021 SET -> WAIT (one cycle for the cells to settle) -> CHECK.
REQ-022 In CHECK, evaluate the eight win lines on cell_valid/cell_symbol; a line is won when all three cells are valid with equal symbol.
REQ-023 CHECK outcome, registered at the next edge: win -> OVER, winner = turn-encoded (X = 01, O = 10); no win and all nine valid -> OVER, winner = 11; otherwise toggle turn -> IDLE.
REQ-024 Latency: move accepted at cycle N -> cell_set at N+1 -> CHECK at N+3 -> turn/winner/game_over valid and move_rdy high again (if not over) at N+4.
REQ-025 OVER: game_over = 1, move_rdy = 0, move_vld ignored; held until new_game or reset.
REQ-026 new_game in any state -> CLEAR; CLEAR asserts cell_reset for one cycle, then IDLE with turn = FIRST_PLAYER, winner = 00, game_over = 0.
REQ-027 new_game in the same cycle as an accepted move: new_game wins, and the move is dropped without an illegal pulse.
REQ-028 cell_set SHALL be all-zero in every state except SET.

Reset
REQ-029 reset SHALL take priority over new_game and move_vld.
REQ-030 While reset = 1: cell_reset = 1 (combinational) and the FSM is forced to IDLE.
REQ-031 Values after reset: turn = FIRST_PLAYER; winner = 00; game_over = 0; illegal = 0; cell_set = 0; latched index = 0.

Configuration
REQ-032 Macro TTT_ILLEGAL_CNT_EN defined: add output illegal_cnt, 8 bits, counting illegal pulses, saturating at 255, cleared by reset and by CLEAR.
REQ-033 Macro TTT_ILLEGAL_CNT_EN absent: no illegal_cnt port or counter; all other behaviour identical.

Structure
REQ-034 Package ttt_pkg SHALL hold: the state enum; winner codes; NUM_CELLS = 9; the 8x3 win-line index table.
REQ-035 Sub-module ttt_win_check SHALL be purely combinational, taking the valid/symbol vectors and returning win, win_symbol and full.

Verification
REQ-036 Reset -> turn = 0, winner = 00, game_over = 0, move_rdy = 1, cell_reset = 1 during reset.
REQ-037 Move to idx 4 at cycle N -> cell_set = 9'h010 and set_symbol = 0 at N+1; turn = 1 and move_rdy = 1 at N+4.
REQ-038 Repeat move to idx 4 -> illegal pulses once; turn unchanged; idx 9 -> illegal pulses once; with TTT_ILLEGAL_CNT_EN defined, illegal_cnt = 2.
REQ-039 X plays 0,1,2 and O plays 3,4 -> winner = 01, game_over = 1; subsequent move_vld is ignored and cell_set stays 0.
REQ-040 Full board with no line (X: 0,2,3,7,5; O: 1,4,6,8) -> winner = 11.
REQ-041 new_game raised mid-SET and in the same cycle as move_vld -> one cell_reset pulse, then IDLE with turn = FIRST_PLAYER and no illegal pulse.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe move controller.
// States, winner codes, board size and the eight win lines.
package ttt_pkg;

  localparam int NUM_CELLS = 9;

  typedef enum logic [2:0] {
    IDLE,
    SET,
    WAIT,
    CHECK,
    OVER,
    CLEAR
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Rows, columns, then both diagonals.
  localparam logic [7:0][2:0][3:0] WIN_LINES = {
    {4'd2, 4'd4, 4'd6},
    {4'd0, 4'd4, 4'd8},
    {4'd2, 4'd5, 4'd8},
    {4'd1, 4'd4, 4'd7},
    {4'd0, 4'd3, 4'd6},
    {4'd6, 4'd7, 4'd8},
    {4'd3, 4'd4, 4'd5},
    {4'd0, 4'd1, 4'd2}
  };

  function automatic logic [1:0] win_code(input logic sym);
    return sym ? WIN_O : WIN_X;
  endfunction

endpackage

// File: rtl/ttt_win_check.sv
// Combinational board evaluator: any completed line, its symbol,
// and whether all nine cells are occupied.
module ttt_win_check
  import ttt_pkg::*;
(
  input  logic [NUM_CELLS-1:0] cell_valid,
  input  logic [NUM_CELLS-1:0] cell_symbol,
  output logic                 win,
  output logic                 win_symbol,
  output logic                 full
);

  // Scan all eight lines for three equal, occupied cells.
  always_comb begin
    win        = 1'b0;
    win_symbol = 1'b0;
    full       = &cell_valid;
    for (int l = 0; l < 8; l++) begin
      if (cell_valid[WIN_LINES[l][0]] &&
          cell_valid[WIN_LINES[l][1]] &&
          cell_valid[WIN_LINES[l][2]] &&
          (cell_symbol[WIN_LINES[l][0]] ==
           cell_symbol[WIN_LINES[l][1]]) &&
          (cell_symbol[WIN_LINES[l][1]] ==
           cell_symbol[WIN_LINES[l][2]])) begin
        win        = 1'b1;
        win_symbol = cell_symbol[WIN_LINES[l][0]];
      end
    end
  end

endmodule

// File: rtl/ttt_move_ctrl.sv
// Tic-tac-toe move controller: accepts moves, strobes cells, scores.
// Optional TTT_ILLEGAL_CNT_EN adds a saturating illegal-move counter.
module ttt_move_ctrl
  import ttt_pkg::*;
#(
  parameter bit FIRST_PLAYER = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 new_game,
  input  logic                 move_vld,
  input  logic [3:0]           move_idx,
  output logic                 move_rdy,
  input  logic [NUM_CELLS-1:0] cell_valid,
  input  logic [NUM_CELLS-1:0] cell_symbol,
  output logic [NUM_CELLS-1:0] cell_set,
  output logic                 set_symbol,
  output logic                 cell_reset,
  output logic                 turn,
  output logic                 game_over,
  output logic [1:0]           winner,
  output logic                 illegal
`ifdef TTT_ILLEGAL_CNT_EN
  ,
  output logic [7:0]           illegal_cnt
`endif
);

  state_t      state;
  state_t      state_nx;
  logic [3:0]  idx;
  logic [15:0] vext;
  logic        accept;
  logic        bad;
  logic        win;
  logic        win_symbol;
  logic        full;

  assign vext   = {7'b0, cell_valid};
  assign accept = (state == IDLE) && move_vld;
  assign bad    = (move_idx > 4'd8) || vext[move_idx];

  ttt_win_check u_win (
    .cell_valid  (cell_valid),
    .cell_symbol (cell_symbol),
    .win         (win),
    .win_symbol  (win_symbol),
    .full        (full)
  );

  // State register; reset forces IDLE.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and strobe outputs; new_game overrides everything.
  always_comb begin
    state_nx   = state;
    move_rdy   = (state == IDLE);
    cell_set   = '0;
    set_symbol = turn;
    cell_reset = reset || (state == CLEAR);
    unique case (state)
      IDLE:  if (move_vld && !bad) state_nx = SET;
      SET: begin
        cell_set = 9'd1 << idx;
        state_nx = WAIT;
      end
      WAIT:  state_nx = CHECK;
      CHECK: state_nx = (win || full) ? OVER : IDLE;
      OVER:  state_nx = OVER;
      CLEAR: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (new_game) state_nx = CLEAR;
  end

  // Turn, score, latched index and illegal pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      turn      <= FIRST_PLAYER;
      winner    <= WIN_NONE;
      game_over <= 1'b0;
      illegal   <= 1'b0;
      idx       <= '0;
    end else begin
      illegal <= accept && bad && !new_game;
      if (accept && !bad && !new_game) idx <= move_idx;
      if (state == CLEAR) begin
        turn      <= FIRST_PLAYER;
        winner    <= WIN_NONE;
        game_over <= 1'b0;
      end else if (state == CHECK && !new_game) begin
        // A fresh line can only belong to the player who just moved.
        if (win) begin
          winner    <= win_code(win_symbol);
          game_over <= 1'b1;
        end else if (full) begin
          winner    <= WIN_DRAW;
          game_over <= 1'b1;
        end else begin
          turn <= ~turn;
        end
      end
    end
  end

`ifdef TTT_ILLEGAL_CNT_EN
  // Saturating count of illegal pulses, wiped with the board.
  always_ff @(posedge clk) begin
    if (reset)                             illegal_cnt <= '0;
    else if (state == CLEAR)               illegal_cnt <= '0;
    else if (illegal && illegal_cnt != '1) illegal_cnt <= illegal_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_ttt_move_ctrl.sv
// Bench for ttt_move_ctrl: cell array, game model, directed + random.
// Optional TTT_ILLEGAL_CNT_EN also checks illegal_cnt.
module tb_ttt_move_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       new_game = 1'b0;
  logic       move_vld = 1'b0;
  logic [3:0] move_idx = 4'd0;
  logic       move_rdy;
  logic [8:0] cell_valid = '0;
  logic [8:0] cell_symbol = '0;
  logic [8:0] cell_set;
  logic       set_symbol;
  logic       cell_reset;
  logic       turn;
  logic       game_over;
  logic [1:0] winner;
  logic       illegal;
`ifdef TTT_ILLEGAL_CNT_EN
  logic [7:0] illegal_cnt;
`endif

  ttt_move_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .new_game    (new_game),
    .move_vld    (move_vld),
    .move_idx    (move_idx),
    .move_rdy    (move_rdy),
    .cell_valid  (cell_valid),
    .cell_symbol (cell_symbol),
    .cell_set    (cell_set),
    .set_symbol  (set_symbol),
    .cell_reset  (cell_reset),
    .turn        (turn),
    .game_over   (game_over),
    .winner      (winner),
    .illegal     (illegal)
`ifdef TTT_ILLEGAL_CNT_EN
    ,
    .illegal_cnt (illegal_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // The nine board cells: registered, cleared by cell_reset.
  always @(posedge clk) begin
    if (cell_reset) begin
      cell_valid  <= '0;
      cell_symbol <= '0;
    end else begin
      for (int i = 0; i < 9; i++)
        if (cell_set[i]) begin
          cell_valid[i]  <= 1'b1;
          cell_symbol[i] <= set_symbol;
        end
    end
  end

  // Game model: board, whose move, outcome known at acceptance
  // and published four cycles later.
  int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  bit       m_ok = 0;
  bit       m_clear, m_over, m_turn, m_ill, n_ill;
  bit       p_win, p_full;
  int       m_busy, m_idx, m_cnt;
  bit [1:0] m_winner;
  bit [8:0] mb_v, mb_s;

  function automatic bit has_line();
    for (int l = 0; l < 8; l++) begin
      int a, b, c;
      a = lines[l][0];
      b = lines[l][1];
      c = lines[l][2];
      if (mb_v[a] && mb_v[b] && mb_v[c] &&
          mb_s[a] == mb_s[b] && mb_s[b] == mb_s[c])
        return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ok = 1; m_clear = 0; m_over = 0; m_turn = 0;
      m_ill = 0; m_busy = 0; m_idx = 0; m_cnt = 0;
      m_winner = 0; mb_v = 0; mb_s = 0;
    end else begin
      n_ill = 0;
      if (m_clear) begin
        m_turn = 0; m_winner = 0; m_over = 0; m_cnt = 0;
        mb_v = 0; mb_s = 0;
      end else if (m_ill && m_cnt < 255) begin
        m_cnt++;
      end
      if (new_game) begin
        m_clear = 1;
        m_busy  = 0;
      end else if (m_clear) begin
        m_clear = 0;
      end else if (m_busy == 3) begin
        m_busy = 0;
        if (p_win) begin
          m_winner = m_turn ? 2'd2 : 2'd1;
          m_over   = 1;
        end else if (p_full) begin
          m_winner = 2'd3;
          m_over   = 1;
        end else begin
          m_turn = ~m_turn;
        end
      end else if (m_busy > 0) begin
        m_busy++;
      end else if (!m_over && move_vld) begin
        if (move_idx > 8) n_ill = 1;
        else if (mb_v[move_idx]) n_ill = 1;
        else begin
          mb_v[move_idx] = 1;
          mb_s[move_idx] = m_turn;
          p_win  = has_line();
          p_full = &mb_v;
          m_idx  = int'(move_idx);
          m_busy = 1;
        end
      end
      m_ill = n_ill;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_ok) begin
      check("move_rdy", 16'(move_rdy),
            16'(!m_clear && m_busy == 0 && !m_over));
      check("cell_set", 16'(cell_set),
            (m_busy == 1) ? (16'd1 << m_idx) : 16'd0);
      check("set_symbol", 16'(set_symbol), 16'(m_turn));
      check("cell_reset", 16'(cell_reset), 16'(reset || m_clear));
      check("turn", 16'(turn), 16'(m_turn));
      check("game_over", 16'(game_over), 16'(m_over));
      check("winner", 16'(winner), 16'(m_winner));
      check("illegal", 16'(illegal), 16'(m_ill));
`ifdef TTT_ILLEGAL_CNT_EN
      check("illegal_cnt", 16'(illegal_cnt), 16'(m_cnt));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic play(input int i);
    move_vld = 1'b1;
    move_idx = 4'(i);
    tick();
    move_vld = 1'b0;
  endtask

  task automatic settle();
    repeat (3) tick();
  endtask

  task automatic restart();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check("clear_pulse", 16'(cell_reset), 16'd1);
    tick();
  endtask

  int win_seq[5]  = '{0, 3, 1, 4, 2};
  int draw_seq[9] = '{0, 1, 2, 4, 3, 6, 7, 8, 5};

  initial begin
    repeat (2) tick();
    check("rst_cell_reset", 16'(cell_reset), 16'd1);
    check("rst_turn", 16'(turn), 16'd0);
    check("rst_winner", 16'(winner), 16'd0);
    check("rst_game_over", 16'(game_over), 16'd0);
    check("rst_move_rdy", 16'(move_rdy), 16'd1);
    reset = 1'b0;
    tick();

    play(4);
    check("set_onehot", 16'(cell_set), 16'h010);
    check("set_sym", 16'(set_symbol), 16'd0);
    settle();
    check("turn_after", 16'(turn), 16'd1);
    check("rdy_after", 16'(move_rdy), 16'd1);

    play(4);
    check("dup_illegal", 16'(illegal), 16'd1);
    tick();
    check("dup_pulse_end", 16'(illegal), 16'd0);
    check("dup_turn", 16'(turn), 16'd1);
    play(9);
    check("range_illegal", 16'(illegal), 16'd1);
    tick();
    check("range_pulse_end", 16'(illegal), 16'd0);
`ifdef TTT_ILLEGAL_CNT_EN
    check("cnt_two", 16'(illegal_cnt), 16'd2);
`endif

    restart();
    check("ng_turn", 16'(turn), 16'd0);
    check("ng_board", 16'(cell_valid), 16'd0);
    foreach (win_seq[k]) begin
      play(win_seq[k]);
      settle();
    end
    check("x_winner", 16'(winner), 16'd1);
    check("x_over", 16'(game_over), 16'd1);
    check("x_rdy", 16'(move_rdy), 16'd0);
    play(5);
    check("over_no_set", 16'(cell_set), 16'd0);
    tick();
    check("over_no_set2", 16'(cell_set), 16'd0);
    check("over_no_ill", 16'(illegal), 16'd0);

    restart();
    foreach (draw_seq[k]) begin
      play(draw_seq[k]);
      settle();
    end
    check("draw_winner", 16'(winner), 16'd3);
    check("draw_over", 16'(game_over), 16'd1);

    restart();
    play(4);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check("midset_clear", 16'(cell_reset), 16'd1);
    check("midset_ill", 16'(illegal), 16'd0);
    tick();
    check("midset_turn", 16'(turn), 16'd0);
    check("midset_rdy", 16'(move_rdy), 16'd1);
    check("midset_board", 16'(cell_valid), 16'd0);

    new_game = 1'b1;
    play(4);
    new_game = 1'b0;
    check("same_clear", 16'(cell_reset), 16'd1);
    check("same_ill", 16'(illegal), 16'd0);
    check("same_set", 16'(cell_set), 16'd0);
    tick();
    check("same_ill2", 16'(illegal), 16'd0);
    check("same_rdy", 16'(move_rdy), 16'd1);
    check("same_board", 16'(cell_valid), 16'd0);

    repeat (4000) begin
      reset    = ($urandom % 150) == 0;
      new_game = ($urandom % 40) == 0;
      move_vld = $urandom % 2;
      move_idx = ($urandom % 8 == 0) ? 4'($urandom_range(9, 15))
                                      : 4'($urandom_range(0, 8));
      tick();
    end
    reset = 1'b0;
    new_game = 1'b0;
    move_vld = 1'b0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
